// File: rtl/car_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// car_frame_tx_pkg
// Shared definitions for the serial car-record link (transmitter and the
// speed receiver):
//   - default bus / car-id widths
//   - frame state encoding (IDLE, ID, X, Y, CALC, GAPW)
//   - packed detection record {id, x, y} at the default widths
// -----------------------------------------------------------------------------
package car_frame_tx_pkg;

    localparam int CAR_WIDTH = 8;   // bus / coordinate width
    localparam int CAR_DEPTH = 6;   // car id width, never wider than CAR_WIDTH

    // Each beat state is entered on the edge that issues that beat.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ID   = 3'd1,
        ST_X    = 3'd2,
        ST_Y    = 3'd3,
        ST_CALC = 3'd4,
        ST_GAPW = 3'd5
    } car_state_e;

    typedef struct packed {
        logic [CAR_DEPTH-1:0] id;
        logic [CAR_WIDTH-1:0] x;
        logic [CAR_WIDTH-1:0] y;
    } car_rec_t;

endpackage

// File: rtl/car_rec_fifo.sv
// -----------------------------------------------------------------------------
// car_rec_fifo
// Synchronous record FIFO, 2**AW entries of W bits.
//   clk, rst_n     : clock, asynchronous active-low reset (pointers/count only)
//   push_i,wdata_i : write a word (caller guarantees !full_o)
//   pop_i          : drop the head word (caller guarantees !empty_o)
//   rdata_o        : head word, valid whenever !empty_o (look-ahead output so
//                    the consumer can use it on the same edge it pops)
//   full_o,empty_o : occupancy flags, combinational from the count register
// -----------------------------------------------------------------------------
module car_rec_fifo #(
    parameter int W  = 22,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int N = 2 ** AW;

    logic [W-1:0]  mem_q [N];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    // Storage carries no reset: contents are only read once written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == (AW+1)'(N));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/car_frame_tx.sv
// -----------------------------------------------------------------------------
// car_frame_tx
// Transmit side of the serial car-record link. Buffers (id, x, y) records and
// sends each as a strobed 4-beat frame ID -> X -> Y -> CALC on a byte bus.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_ready     : record push handshake (s_ready = FIFO not full)
//   s_id, s_x, s_y      : record fields
//   i_hold              : downstream pause, freezes the frame engine
//   o_car, o_start      : beat byte (stable until next beat) and beat strobe
//   o_busy              : frame in progress or records queued
//   o_frames            : completed-frame counter (wraps at 2^16)
// -----------------------------------------------------------------------------
module car_frame_tx
    import car_frame_tx_pkg::*;
#(
    parameter int WIDTH   = CAR_WIDTH,
    parameter int DEPTH   = CAR_DEPTH,
    parameter int FIFO_AW = 2,
    parameter int GAP     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DEPTH-1:0] s_id,
    input  logic [WIDTH-1:0] s_x,
    input  logic [WIDTH-1:0] s_y,
    input  logic             i_hold,
    output logic [WIDTH-1:0] o_car,
    output logic             o_start,
    output logic             o_busy,
    output logic [15:0]      o_frames
);

    localparam int REC_W = DEPTH + 2 * WIDTH;
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REC_W-1:0]   fifo_rdata;

    car_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] xy_q, xy_d;       // x/y of the frame being sent
    logic [GW-1:0]      gap_q, gap_d;
    logic [WIDTH-1:0]   car_q, car_d;
    logic               start_q, beat;
    logic               busy_q, busy_d;
    logic [15:0]        frames_q, frames_d;

    assign s_ready = !fifo_full;
    assign push    = s_valid & s_ready;

    car_rec_fifo #(
        .W  (REC_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({s_id, s_x, s_y}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        xy_d     = xy_q;
        gap_d    = gap_q;
        car_d    = car_q;
        frames_d = frames_q;
        beat     = 1'b0;
        pop      = 1'b0;

        // A held edge changes nothing, so the pending beat simply slides.
        if (!i_hold) begin
            unique case (state_q)
                ST_IDLE: begin
                    pop = !fifo_empty;
                end
                ST_ID: begin
                    state_d = ST_X;
                    beat    = 1'b1;
                    car_d   = xy_q[2*WIDTH-1 -: WIDTH];
                end
                ST_X: begin
                    state_d = ST_Y;
                    beat    = 1'b1;
                    car_d   = xy_q[WIDTH-1:0];
                end
                ST_Y: begin
                    state_d  = ST_CALC;
                    beat     = 1'b1;
                    car_d    = '0;
                    frames_d = frames_q + 16'd1;
                end
                ST_CALC: begin
                    if (GAP > 0) begin
                        // Leaving CALC is itself the first gap cycle.
                        state_d = ST_GAPW;
                        gap_d   = '0;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GAPW: begin
                    if (int'(gap_q) >= GAP - 1) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Popping a record issues its ID beat on the same edge; the ID
            // is taken straight from the FIFO head.
            if (pop) begin
                state_d = ST_ID;
                beat    = 1'b1;
                car_d   = WIDTH'(fifo_rdata[REC_W-1 -: DEPTH]);
                xy_d    = fifo_rdata[2*WIDTH-1:0];
            end
        end

        // Any pop moves the FSM out of IDLE, so only an un-popped FIFO
        // and a fresh push need to be added here.
        busy_d = (state_d != ST_IDLE) | push | !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            xy_q     <= '0;
            gap_q    <= '0;
            car_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            xy_q     <= xy_d;
            gap_q    <= gap_d;
            car_q    <= car_d;
            start_q  <= beat;
            busy_q   <= busy_d;
            frames_q <= frames_d;
        end
    end

    assign o_car    = car_q;
    assign o_start  = start_q;
    assign o_busy   = busy_q;
    assign o_frames = frames_q;

endmodule

// File: tb/tb_car_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_car_frame_tx
// Drives two car_frame_tx instances (GAP=0 and GAP=2) with the same inputs and
// compares every cycle against a frame-level reference model per instance:
// a record queue plus a list of beats still owed for the current frame.
// -----------------------------------------------------------------------------
module tb_car_frame_tx;

    localparam int CAP      = 4;
    localparam int CALC_TOK = 256;   // CALC beat: byte 0, counts a frame
    localparam int GAP_TOK  = -1;    // gap cycle: no beat

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [5:0] s_id;
    logic [7:0] s_x;
    logic [7:0] s_y;
    logic       i_hold;

    logic       ready_o  [2];
    logic [7:0] car_o    [2];
    logic       start_o  [2];
    logic       busy_o   [2];
    logic [15:0] frames_o [2];

    car_frame_tx #(.WIDTH(8), .DEPTH(6), .FIFO_AW(2), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(ready_o[0]),
        .s_id(s_id), .s_x(s_x), .s_y(s_y), .i_hold(i_hold),
        .o_car(car_o[0]), .o_start(start_o[0]), .o_busy(busy_o[0]),
        .o_frames(frames_o[0])
    );

    car_frame_tx #(.WIDTH(8), .DEPTH(6), .FIFO_AW(2), .GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(ready_o[1]),
        .s_id(s_id), .s_x(s_x), .s_y(s_y), .i_hold(i_hold),
        .o_car(car_o[1]), .o_start(start_o[1]), .o_busy(busy_o[1]),
        .o_frames(frames_o[1])
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_fifo [2][$];   // queued records, id<<16 | x<<8 | y
    int          m_todo [2][$];   // beats/gaps still owed by current frame
    logic [7:0]  m_car    [2];
    bit          m_start  [2];
    bit          m_active [2];    // FSM not idle
    logic [15:0] m_frames [2];
    int          m_cur    [2];
    int          gap_of   [2] = '{0, 2};

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            m_fifo[k].delete();
            m_todo[k].delete();
            m_car[k]    = '0;
            m_start[k]  = 1'b0;
            m_active[k] = 1'b0;
            m_frames[k] = '0;
            m_cur[k]    = 0;
        end
    endtask

    // One rising edge for instance k, using the inputs present before it.
    task automatic model_edge(int k);
        bit push;
        int item;
        push = s_valid && (m_fifo[k].size() < CAP);
        m_start[k] = 1'b0;
        if (!i_hold) begin
            if (m_todo[k].size() > 0) begin
                item = m_todo[k].pop_front();
                m_active[k] = 1'b1;
                if (item == CALC_TOK) begin
                    m_car[k]    = '0;
                    m_start[k]  = 1'b1;
                    m_frames[k] = m_frames[k] + 16'd1;
                    $display("frame dut%0d n=%0d id=%0d x=%0d y=%0d", k, m_frames[k],
                             m_cur[k] >> 16, (m_cur[k] >> 8) & 255, m_cur[k] & 255);
                end else if (item != GAP_TOK) begin
                    m_car[k]   = 8'(item);
                    m_start[k] = 1'b1;
                end
            end else if (m_fifo[k].size() > 0) begin
                m_cur[k]    = m_fifo[k].pop_front();
                m_car[k]    = 8'(m_cur[k] >> 16);
                m_start[k]  = 1'b1;
                m_active[k] = 1'b1;
                m_todo[k].push_back((m_cur[k] >> 8) & 255);
                m_todo[k].push_back(m_cur[k] & 255);
                m_todo[k].push_back(CALC_TOK);
                for (int g = 0; g < gap_of[k]; g++) m_todo[k].push_back(GAP_TOK);
            end else begin
                m_active[k] = 1'b0;
            end
        end
        if (push) m_fifo[k].push_back((int'(s_id) << 16) | (int'(s_x) << 8) | int'(s_y));
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("car%0d", k),    car_o[k],    m_car[k]);
            check_eq($sformatf("start%0d", k),  start_o[k],  m_start[k]);
            check_eq($sformatf("busy%0d", k),   busy_o[k],
                     int'(m_active[k] || m_fifo[k].size() > 0));
            check_eq($sformatf("frames%0d", k), frames_o[k], m_frames[k]);
            check_eq($sformatf("ready%0d", k),  ready_o[k],  int'(m_fifo[k].size() < CAP));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_rec(bit v, int id, int x, int y);
        s_valid = v;
        s_id    = 6'(id);
        s_x     = 8'(x);
        s_y     = 8'(y);
    endtask

    task automatic drain(int n);
        set_rec(1'b0, 0, 0, 0);
        i_hold = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    int starts;

    initial begin
        rst_n = 1'b1;
        set_rec(1'b0, 0, 0, 0);
        i_hold = 1'b0;
        reset_model();
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single record: beats 5, 40, 120, 0 on the four edges after the push.
        set_rec(1'b1, 5, 40, 120);
        step();
        set_rec(1'b0, 0, 0, 0);
        step(); check_eq("s1_id", car_o[0], 5);   check_eq("s1_id_stb", start_o[0], 1);
        step(); check_eq("s1_x", car_o[0], 40);
        step(); check_eq("s1_y", car_o[0], 120);
        step(); check_eq("s1_calc", car_o[0], 0); check_eq("s1_frames", frames_o[0], 1);
        step(); check_eq("s1_idle_stb", start_o[0], 0); check_eq("s1_idle_busy", busy_o[0], 0);
        drain(6);

        // Three back-to-back records; GAP=2 instance must idle 2 cycles.
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            set_rec(i < 3, 10 + i, 3 * i + 1, 200 + i);
            step();
            if (i >= 1 && i <= 12) starts += int'(start_o[0]);
            if (i == 5 || i == 6) check_eq("s2_gap_stb", start_o[1], 0);
            if (i == 7) begin
                check_eq("s2_gap_id_stb", start_o[1], 1);
                check_eq("s2_gap_id", car_o[1], 11);
            end
        end
        check_eq("s2_starts", starts, 12);
        check_eq("s2_frames", frames_o[0], 4);
        drain(20);

        // Hold for three edges starting at the X beat edge.
        set_rec(1'b1, 7, 77, 177);
        step();
        set_rec(1'b0, 0, 0, 0);
        step();
        i_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("s3_hold_car", car_o[0], 7);
            check_eq("s3_hold_stb", start_o[0], 0);
        end
        i_hold = 1'b0;
        step(); check_eq("s3_x", car_o[0], 77); check_eq("s3_x_stb", start_o[0], 1);
        step(); check_eq("s3_y", car_o[0], 177);
        drain(10);

        // Fill the FIFO under hold, then release.
        i_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rec(1'b1, 20 + i, 30 + i, 40 + i);
            step();
        end
        check_eq("s4_full", ready_o[0], 0);
        set_rec(1'b1, 24, 34, 44);
        step();
        check_eq("s4_still_full", ready_o[0], 0);
        i_hold = 1'b0;
        step();
        check_eq("s4_pop_ready", ready_o[0], 1);
        check_eq("s4_pop_id", car_o[0], 20);
        step();
        drain(40);

        // Asynchronous reset during the Y beat.
        set_rec(1'b1, 33, 34, 35);
        step();
        set_rec(1'b0, 0, 0, 0);
        step(); step(); step();
        check_eq("s5_y", car_o[0], 35);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("s5_rst_car", car_o[k], 0);
            check_eq("s5_rst_stb", start_o[k], 0);
            check_eq("s5_rst_busy", busy_o[k], 0);
            check_eq("s5_rst_frames", frames_o[k], 0);
            check_eq("s5_rst_ready", ready_o[k], 1);
        end
        reset_model();
        step();
        rst_n = 1'b1;
        set_rec(1'b1, 9, 1, 2);
        step();
        set_rec(1'b0, 0, 0, 0);
        step();
        check_eq("s5_new_id", car_o[0], 9);
        check_eq("s5_new_stb", start_o[0], 1);
        drain(10);

        // Random traffic with random holds.
        for (int i = 0; i < 400; i++) begin
            set_rec(1'($urandom), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            i_hold = ($urandom_range(0, 3) == 0);
            step();
        end
        drain(40);
        check_eq("end_idle0", busy_o[0], 0);
        check_eq("end_idle1", busy_o[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_frame_tx.md
# car_frame_tx

- Transmit side of the serial car-record link: accepts complete detection records (id, x, y) from the detection front end over a valid/ready port and buffers them in a small FIFO.
- Emits each record as a strobed 4-beat frame on a byte-wide car bus (o_car with o_start), which feeds the speed computation block's i_car/start inputs.
- Guarantees the beat ordering, byte stability and idle behaviour that the speed receiver's ID→X→Y→CALC state sequence depends on.

## Interface
- WIDTH, 8, bus/coordinate width in bits
- DEPTH, 6, car id width in bits; DEPTH ≤ WIDTH
- FIFO_AW, 2, FIFO address bits; capacity 2**FIFO_AW records
- GAP, 0, idle cycles (o_start=0) inserted after each CALC beat; 0 = back-to-back frames
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  record offered
- s_ready  out  1  FIFO can accept; = !full
- s_id  in  DEPTH  car id
- s_x  in  WIDTH  x coordinate
- s_y  in  WIDTH  y coordinate
- i_hold  in  1  downstream pause; no beat issued at an edge where i_hold=1
- o_car  out  WIDTH  current beat byte
- o_start  out  1  beat strobe
- o_busy  out  1  FIFO non-empty or frame in progress
- o_frames  out  16  completed-frame counter

## Operation
- Push: s_valid & s_ready at a rising edge writes {s_id, s_x, s_y} into the FIFO.
- Push and pop at the same edge leave the FIFO count unchanged. A push while full is impossible because s_ready=0.
- FSM states and next-state rules (advance only at edges where i_hold=0, otherwise hold state):
  - IDLE: FIFO non-empty → ID (pops record into the frame register).
  - ID → X.
  - X → Y.
  - Y → CALC.
  - CALC: GAP>0 → GAPW; GAP=0 & FIFO non-empty → ID (pop); otherwise → IDLE.
  - GAPW: count GAP cycles (the count is frozen while i_hold=1), then FIFO non-empty → ID (pop), otherwise → IDLE.
- Beat outputs on entering each state:
  - ID: o_car = {0, id}, zero-extended.
  - X: o_car = x.
  - Y: o_car = y.
  - CALC: o_car = 0.
- o_start=1 exactly in the cycle following each beat edge. o_start=0 in IDLE, GAPW and any held cycle.
- o_car stays stable from its beat until the next beat, so the receiver may sample it in any cycle before the next strobe.
- o_frames increments (mod 2^16) on each CALC beat.
- Reset (any time, including mid-frame) immediately forces:
  - o_car=0, o_start=0, o_busy=0, o_frames=0;
  - FIFO empty, FSM=IDLE;
  - partial frame discarded.
- s_ready=1 after reset release.

## Timing
- Reset values: o_car=0, o_start=0, o_busy=0, o_frames=0, s_ready=1.
- Latency: a record pushed at edge t into an empty FIFO with the FSM in IDLE gives ID beat at edge t+1, X at t+2, Y at t+3, CALC at t+4.
- Back-to-back throughput with GAP=0 and no hold: 1 frame per 4 cycles; the next ID beat lands at t+5.
- i_hold=1 at an edge suppresses that edge's beat. The suppressed beat is issued at the first edge with i_hold=0, with no beat skipped or repeated.
- s_ready is combinational from the FIFO count. A pop frees a slot, and s_ready=1 in the cycle after the pop edge.
- o_busy = (state≠IDLE) | FIFO non-empty, registered.

## Structure
- Shared package: beat/state encoding (IDLE, ID, X, Y, CALC, GAPW), the WIDTH/DEPTH defaults, and the record struct {id, x, y}. The speed receiver uses the same package.
- One sub-module: car_rec_fifo, a synchronous FIFO with parameters width = DEPTH+2·WIDTH and AW = FIFO_AW, and full/empty flags.
- The FSM, frame register, gap counter and frame counter stay in car_frame_tx.

## Test plan
- Single record id=5, x=40, y=120 pushed at edge 0 → beats at edges 1..4 with o_car = 5, 40, 120, 0 and o_start=1 in each of those cycles → IDLE, o_frames=1, o_busy=0.
- Three records pushed on consecutive edges, GAP=0 → 12 consecutive strobed beats with no o_start gap → o_frames=3.
- i_hold=1 for 3 cycles starting at the X beat edge → X beat delayed exactly 3 cycles, o_car held at id during the hold → Y and CALC follow normally.
- s_valid held high with i_hold=1 throughout (FIFO_AW=2) → 4 pushes accepted, then s_ready=0. Release hold → s_ready=1 one cycle after the first pop, and the 5th record is accepted.
- rst_n asserted during the Y beat → o_start=0 and o_car=0 immediately. After release, o_frames=0 and s_ready=1, and a new record produces a clean ID-first frame.
- GAP=2, two queued records → o_start=0 for exactly 2 cycles between CALC and the next ID.
